tx_pattern_gen: RTL and testbench
=================================

Name: tx_pattern_gen

Overview:
- Transmit-side pattern source for CDR bring-up and BER testing.
- Emits 64-bit parallel words toward the serializer: a clock-like preamble first, so the receiver CDR can acquire phase, then a selectable payload (zeros, clock pattern, PRBS7/15/31, or a user word).
- Uses a valid/ready handshake to the serializer FIFO.
- Supports single-bit error injection, so the receiver checker's error_flag can be exercised.

Parameters:
- W, 64, word width. tx_data[0] is the first bit sent on the line.
- PRE_W, 10, width of the preamble length field.
- CNT_W, 32, width of the accepted-word counter.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous, active-high reset.
- en, input, 1, level. Starts and stops generation.
- pat_sel, input, 3, payload select: 0 zeros, 1 clock {16{4'b0110}}, 2 PRBS7, 3 PRBS15, 4 PRBS31, 5 user_word; 6/7 behave as 0.
- pre_len, input, PRE_W, number of preamble words to send.
- user_word, input, W, payload word used when pat_sel=5.
- err_inj, input, 1, pulse requesting one bit flip.
- tx_ready, input, 1, downstream accepts the current word.
- tx_valid, output, 1, tx_data is valid.
- tx_data, output, W, output word.
- state, output, 2, 0 IDLE, 1 PREAMBLE, 2 PAYLOAD.
- word_cnt, output, CNT_W, accepted payload words. Wraps around.
- err_cnt, output, 16, injected errors. Saturates at 16'hFFFF.

Behaviour:
- Reset: state=IDLE, tx_valid=0, tx_data=0, word_cnt=0, err_cnt=0, LFSR=all-ones, inject-pending flag=0. Reset takes priority over everything, including mid-transfer.
- Acceptance: a word is accepted on a cycle where tx_valid && tx_ready. All outputs are registered.
- Stall: while tx_valid && !tx_ready, tx_data and tx_valid hold stable and the LFSR and counters do not advance.
- IDLE:
  - tx_valid=0.
  - en=1 → PREAMBLE on the next cycle, with pre_len captured into a down-counter.
  - If pre_len=0 → PAYLOAD directly.
- PREAMBLE:
  - tx_valid=1, tx_data={16{4'b0110}}.
  - The counter decrements per accepted word.
  - After the last accepted preamble word → PAYLOAD; the first payload word is presented on the next cycle.
- PAYLOAD entry:
  - pat_sel is sampled and held; changes to pat_sel are ignored until the block passes through IDLE again.
  - The LFSR is reseeded.
- PRBS definition, bit-serial, n = line bit index, first 7/15/31 bits = 1:
  - PRBS7: b[n]=b[n-7]^b[n-6].
  - PRBS15: b[n]=b[n-15]^b[n-14].
  - PRBS31: b[n]=b[n-31]^b[n-28].
  - Each accepted word advances the sequence by 64 bits. The next word is computed combinationally from the LFSR state (unrolled 64 steps).
- LFSR lockup: an all-zero LFSR state is reloaded with all-ones on the next cycle.
- Stop: en=0 in PREAMBLE or PAYLOAD → IDLE.
  - If a word is pending unaccepted, the block keeps it valid until it is accepted, then goes to IDLE (no word is dropped or truncated).
  - If en=0 with no word pending, IDLE on the next cycle.
- Restart: en re-asserted in IDLE restarts with a fresh preamble.
- word_cnt increments only on accepted PAYLOAD words. It is not cleared by en, only by rst.
- Error injection:
  - An err_inj pulse sets the pending flag.
  - The next accepted PAYLOAD word carries bit 0 inverted; the flag then clears and err_cnt increments.
  - Pulses while the flag is already set are ignored.
  - Pulses outside PAYLOAD stay pending until payload starts.
  - The flip is applied to the output word only; the LFSR stream is unaffected.

Optional Feature:
- Macro: TX_ERR_INJ_EN.
- Defined: error injection is built as described above.
- Undefined: err_inj is ignored, there is no pending-flag logic, tx_data is never modified, and err_cnt is tied to 0.

Test Plan:
- Reset and preamble: rst for 2 cycles, then en=1, pre_len=4, tx_ready=1 → exactly 4 words of 64'h6666_6666_6666_6666, then state=2.
- PRBS7 with pre_len=0, pat_sel=2:
  - first word tx_data[12:0]=13'h007F and bit13=1;
  - every word obeys the recurrence;
  - word k equals word k+127.
- Backpressure, PRBS15: toggle tx_ready randomly → data held stable while stalled; the accepted stream is identical to the no-stall run; word_cnt equals the number of accepted words.
- Stop while stalled: en=0 while tx_valid=1 and tx_ready=0 → word held until tx_ready=1, then tx_valid=0 and state=0; re-enable → preamble resent.
- Error injection (TX_ERR_INJ_EN defined), PRBS31:
  - one err_inj pulse → exactly one accepted word differs from the reference only at bit 0;
  - err_cnt=1;
  - subsequent words match the reference.
  - A double pulse while pending → err_cnt=1.
- Reset mid-payload: rst=1 during PAYLOAD → next cycle tx_valid=0, word_cnt=0, state=0; after restart the PRBS sequence begins again from the all-ones seed.

Source files
------------

// File: rtl/tx_pattern_gen_if.sv
// Handshake bundle between the pattern generator and the serializer FIFO.
//   tx_valid : generator presents a word
//   tx_ready : FIFO accepts the word on this cycle
//   tx_data  : W-bit word, bit 0 is the first bit on the line
// master = generator side, slave = serializer FIFO side.
interface tx_pattern_gen_if #(
  parameter int unsigned W = 64
) ();
  logic         tx_valid;
  logic         tx_ready;
  logic [W-1:0] tx_data;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/tx_pattern_gen.sv
// Transmit-side pattern source for CDR bring-up and BER testing.
// Sends pre_len clock-like preamble words, then a payload selected by pat_sel:
// 0 zeros, 1 clock {16{4'b0110}}, 2 PRBS7, 3 PRBS15, 4 PRBS31, 5 user_word, 6/7 zeros.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   en            : level, starts/stops generation
//   pat_sel       : payload select, sampled on payload entry
//   pre_len       : number of preamble words
//   user_word     : payload word for pat_sel = 5
//   err_inj       : pulse requesting a bit-0 flip on a later payload word
//   tx            : valid/ready/data bundle toward the serializer (master side)
//   state         : 0 idle, 1 preamble, 2 payload
//   word_cnt      : accepted payload words, wraps
//   err_cnt       : injected errors, saturates
// Build option: define TX_ERR_INJ_EN to include error injection; otherwise err_inj is
// ignored and err_cnt reads 0.
module tx_pattern_gen #(
  parameter int unsigned W     = 64,
  parameter int unsigned PRE_W = 10,
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [2:0]           pat_sel,
  input  logic [PRE_W-1:0]     pre_len,
  input  logic [W-1:0]         user_word,
  input  logic                 err_inj,
  tx_pattern_gen_if.master     tx,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     word_cnt,
  output logic [15:0]          err_cnt
);

  typedef enum logic [1:0] {StIdle = 2'd0, StPreamble = 2'd1, StPayload = 2'd2} state_e;

  localparam logic [W-1:0] ClkWord = {(W/4){4'b0110}};
  localparam logic [30:0]  Seed    = '1;

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic [W-1:0]     data_q, data_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [2:0]       pat_q, pat_d;
  logic [30:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  logic             accept, start_pre, start_payload, load_payload, go_idle, flip_now;
  logic [2:0]       gen_sel;
  logic [30:0]      gen_seed, gen_next, lfsr_mask;
  logic [W-1:0]     gen_word;
  logic [W+30:0]    ext7, ext15, ext31;
  logic             lockup;

  // Bit-serial sequence b[i] = b[i-k] ^ b[i-tap], seeded with the next k line bits.
  // Bits [W-1:0] form the word, bits [W+30:W] are the seed for the following word.
  function automatic logic [W+30:0] prbs_run(input logic [30:0] s, input int k, input int tap);
    logic [W+30:0] ext;
    ext = '0;
    ext[30:0] = s;
    for (int i = 0; i < int'(W) + 31; i++) begin
      if (i >= k) ext[i] = ext[i-k] ^ ext[i-tap];
    end
    return ext;
  endfunction

  assign accept = valid_q && tx.tx_ready;

  // Control: state transitions and the load strobes used by the datapath.
  always_comb begin
    state_d       = state_q;
    pre_cnt_d     = pre_cnt_q;
    start_pre     = 1'b0;
    start_payload = 1'b0;
    load_payload  = 1'b0;
    go_idle       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          if (pre_len == '0) start_payload = 1'b1;
          else               start_pre     = 1'b1;
        end
      end
      StPreamble: begin
        // A stop never drops a presented word: wait for it to be accepted.
        if (!en) go_idle = accept || !valid_q;
        else if (accept) begin
          pre_cnt_d = pre_cnt_q - PRE_W'(1);
          if (pre_cnt_q == PRE_W'(1)) start_payload = 1'b1;
        end
      end
      StPayload: begin
        if (!en) go_idle = accept || !valid_q;
        else if (accept) load_payload = 1'b1;
      end
      default: go_idle = 1'b1;
    endcase
    if (start_pre) begin
      state_d   = StPreamble;
      pre_cnt_d = pre_len;
    end
    if (start_payload) state_d = StPayload;
    if (go_idle)       state_d = StIdle;
  end

  // Payload generator: on entry uses the live pat_sel and a fresh seed.
  always_comb begin
    gen_sel  = (state_q == StPayload) ? pat_q : pat_sel;
    gen_seed = (state_q == StPayload) ? lfsr_q : Seed;
    ext7     = prbs_run(gen_seed, 7, 6);
    ext15    = prbs_run(gen_seed, 15, 14);
    ext31    = prbs_run(gen_seed, 31, 28);
    gen_word = '0;
    gen_next = gen_seed;
    case (gen_sel)
      3'd1: gen_word = ClkWord;
      3'd2: begin gen_word = ext7[W-1:0];  gen_next = ext7[W +: 31];  end
      3'd3: begin gen_word = ext15[W-1:0]; gen_next = ext15[W +: 31]; end
      3'd4: begin gen_word = ext31[W-1:0]; gen_next = ext31[W +: 31]; end
      3'd5: gen_word = user_word;
      default: gen_word = '0;
    endcase
  end

  always_comb begin
    lfsr_mask = '0;
    case (pat_q)
      3'd2:    lfsr_mask = 31'h0000_007F;
      3'd3:    lfsr_mask = 31'h0000_7FFF;
      3'd4:    lfsr_mask = 31'h7FFF_FFFF;
      default: lfsr_mask = '0;
    endcase
    lockup = (state_q == StPayload) && (lfsr_mask != '0) && ((lfsr_q & lfsr_mask) == '0);
  end

  // Datapath next state.
  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    lfsr_d     = lfsr_q;
    pat_d      = pat_q;
    word_cnt_d = word_cnt_q;
    if (accept && (state_q == StPayload)) word_cnt_d = word_cnt_q + CNT_W'(1);
    if (lockup) lfsr_d = Seed;
    if (start_pre) begin
      valid_d = 1'b1;
      data_d  = ClkWord;
    end
    if (start_payload) pat_d = pat_sel;
    if (start_payload || load_payload) begin
      valid_d = 1'b1;
      data_d  = gen_word ^ {{(W-1){1'b0}}, flip_now};
      lfsr_d  = gen_next;
    end
    if (go_idle) begin
      valid_d = 1'b0;
      data_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      valid_q    <= 1'b0;
      data_q     <= '0;
      pre_cnt_q  <= '0;
      pat_q      <= '0;
      lfsr_q     <= Seed;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      pre_cnt_q  <= pre_cnt_d;
      pat_q      <= pat_d;
      lfsr_q     <= lfsr_d;
      word_cnt_q <= word_cnt_d;
    end
  end

`ifdef TX_ERR_INJ_EN
  // inj_q: request waiting for the next loaded payload word.
  // flip_q: the presented word carries the flip and has not been accepted yet.
  logic        inj_q, inj_d, flip_q, flip_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  assign flip_now = (start_payload || load_payload) && inj_q;

  always_comb begin
    inj_d     = inj_q;
    flip_d    = flip_q;
    err_cnt_d = err_cnt_q;
    if (accept && flip_q) begin
      flip_d = 1'b0;
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end
    if (err_inj && !inj_q && !flip_q) inj_d = 1'b1;
    if (flip_now) begin
      inj_d  = 1'b0;
      flip_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inj_q     <= 1'b0;
      flip_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      inj_q     <= inj_d;
      flip_q    <= flip_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err_inj;
  assign unused_err_inj = err_inj;
  assign flip_now       = 1'b0;
  assign err_cnt        = '0;
`endif

  assign tx.tx_valid = valid_q;
  assign tx.tx_data  = data_q;
  assign state       = state_q;
  assign word_cnt    = word_cnt_q;

endmodule

// File: tb/tb_tx_pattern_gen.sv
// Self-checking bench for tx_pattern_gen: a cycle table for preamble/stop/select
// behaviour, then stream runs compared against a bit-serial sequence model.
module tb_tx_pattern_gen;

  localparam logic [63:0] CLK_W = 64'h6666_6666_6666_6666;
  localparam logic [63:0] UW    = 64'hDEAD_BEEF_0123_4567;
`ifdef TX_ERR_INJ_EN
  localparam int InjOn = 1;
`else
  localparam int InjOn = 0;
`endif

  logic        clk, rst, en, err_inj;
  logic [2:0]  pat_sel;
  logic [9:0]  pre_len;
  logic [63:0] user_word;
  logic [1:0]  state;
  logic [31:0] word_cnt;
  logic [15:0] err_cnt;

  tx_pattern_gen_if #(.W(64)) tx_if ();

  tx_pattern_gen #(.W(64), .PRE_W(10), .CNT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pat_sel   (pat_sel),
    .pre_len   (pre_len),
    .user_word (user_word),
    .err_inj   (err_inj),
    .tx        (tx_if),
    .state     (state),
    .word_cnt  (word_cnt),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          rst;
    bit          en;
    logic [2:0]  pat;
    logic [9:0]  pre;
    bit          rdy;
    bit          v;
    logic [1:0]  st;
    logic [63:0] d;
    int          wc;
  } vec_t;

  vec_t        tbl[$];
  logic [63:0] got[$];
  bit          ref_bits[];
  int          model_pat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; err_inj = 1'b0; tx_if.tx_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Reference: line bits straight from the recurrence, first k bits all ones.
  task automatic set_model(input int pat, input int nwords);
    int k, tap;
    model_pat = pat;
    k = 0;
    tap = 0;
    case (pat)
      2: begin k = 7;  tap = 6;  end
      3: begin k = 15; tap = 14; end
      4: begin k = 31; tap = 28; end
      default: ;
    endcase
    ref_bits = new[nwords * 64];
    if (k > 0)
      for (int n = 0; n < nwords * 64; n++)
        ref_bits[n] = (n < k) ? 1'b1 : (ref_bits[n-k] ^ ref_bits[n-tap]);
  endtask

  function automatic logic [63:0] ref_word(input int i);
    logic [63:0] w;
    w = '0;
    case (model_pat)
      1: w = CLK_W;
      2, 3, 4:
        for (int j = 0; j < 64; j++)
          if (i * 64 + j < ref_bits.size()) w[j] = ref_bits[i*64+j];
      5: w = UW;
      default: w = '0;
    endcase
    return w;
  endfunction

  // Collects n accepted payload words; checks that stalled words stay put.
  task automatic run_stream(input string name, input int n, input bit rnd, input int inj_at,
                            input int inj_len, input int budget);
    bit          prev_stall;
    logic [63:0] prev_data;
    int          nstall_bad;
    got.delete();
    prev_stall = 1'b0;
    prev_data  = '0;
    nstall_bad = 0;
    for (int c = 0; c < budget && got.size() < n; c++) begin
      tx_if.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      err_inj = (c >= inj_at) && (c < inj_at + inj_len);
      if (prev_stall && !(tx_if.tx_valid === 1'b1 && tx_if.tx_data === prev_data))
        nstall_bad++;
      if (tx_if.tx_valid && tx_if.tx_ready && state == 2'd2) got.push_back(tx_if.tx_data);
      prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
      prev_data  = tx_if.tx_data;
      step();
    end
    err_inj = 1'b0;
    tx_if.tx_ready = 1'b0;
    check({name, "_len"}, 64'(got.size()), 64'(n));
    check({name, "_stall_hold"}, 64'(nstall_bad), 64'd0);
  endtask

  task automatic cmp_stream(output int ndiff, output int nbad, output int first);
    logic [63:0] d;
    ndiff = 0;
    nbad  = 0;
    first = -1;
    foreach (got[i]) begin
      d = got[i] ^ ref_word(i);
      if (d != '0) begin
        ndiff++;
        if (first < 0) first = i;
        if (d != 64'h1) nbad++;
      end
    end
  endtask

  task automatic add(input bit r, input bit e, input logic [2:0] p, input logic [9:0] pl,
                     input bit rd, input bit v, input logic [1:0] st, input logic [63:0] d,
                     input int wc);
    tbl.push_back('{r, e, p, pl, rd, v, st, d, wc});
  endtask

  initial begin
    int ndiff, nbad, first, nrec;
    logic [63:0] w;
    rst = 1'b1; en = 1'b0; err_inj = 1'b0; pat_sel = '0; pre_len = '0;
    user_word = UW; tx_if.tx_ready = 1'b0;

    //  rst en pat pre rdy | v st data  wc
    add(1, 0, 0, 0, 0,   0, 0, '0,    0);
    add(1, 0, 0, 0, 0,   0, 0, '0,    0);
    add(0, 1, 0, 4, 1,   1, 1, CLK_W, 0);
    add(0, 1, 0, 4, 1,   1, 1, CLK_W, 0);
    add(0, 1, 0, 4, 1,   1, 1, CLK_W, 0);
    add(0, 1, 0, 4, 1,   1, 1, CLK_W, 0);
    add(0, 1, 0, 4, 1,   1, 2, '0,    0);
    add(0, 1, 0, 4, 1,   1, 2, '0,    1);
    add(0, 1, 0, 4, 0,   1, 2, '0,    1);
    add(0, 0, 0, 4, 0,   1, 2, '0,    1);
    add(0, 0, 0, 4, 1,   0, 0, '0,    2);
    add(0, 0, 1, 0, 1,   0, 0, '0,    2);
    add(0, 1, 1, 0, 1,   1, 2, CLK_W, 2);
    add(0, 1, 1, 0, 1,   1, 2, CLK_W, 3);
    add(0, 0, 1, 0, 1,   0, 0, '0,    4);
    add(0, 1, 5, 0, 1,   1, 2, UW,    4);
    add(0, 1, 2, 0, 1,   1, 2, UW,    5);
    add(0, 0, 2, 0, 1,   0, 0, '0,    6);
    add(0, 1, 6, 0, 1,   1, 2, '0,    6);
    add(0, 0, 6, 0, 0,   1, 2, '0,    6);
    add(0, 0, 6, 0, 1,   0, 0, '0,    7);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; en = tbl[i].en; pat_sel = tbl[i].pat; pre_len = tbl[i].pre;
      tx_if.tx_ready = tbl[i].rdy;
      step();
      check($sformatf("tbl%0d_valid", i), 64'(tx_if.tx_valid), 64'(tbl[i].v));
      check($sformatf("tbl%0d_state", i), 64'(state), 64'(tbl[i].st));
      check($sformatf("tbl%0d_data", i), tx_if.tx_data, tbl[i].d);
      check($sformatf("tbl%0d_wcnt", i), 64'(word_cnt), 64'(tbl[i].wc));
      if (i == 1) check("reset_err_cnt", 64'(err_cnt), 64'd0);
    end

    // PRBS7 from reset, no preamble.
    do_reset();
    pat_sel = 3'd2; pre_len = '0; set_model(2, 140); en = 1'b1;
    run_stream("prbs7", 132, 1'b0, 0, 0, 400);
    w = got.size() > 0 ? got[0] : '0;
    check("prbs7_w0_lo13", 64'(w[12:0]), 64'h7F);
    check("prbs7_w0_b13", 64'(w[13]), 64'd1);
    cmp_stream(ndiff, nbad, first);
    check("prbs7_vs_model", 64'(ndiff), 64'd0);
    nrec = 0;
    for (int n = 7; n < got.size() * 64; n++)
      if (got[n/64][n%64] != (got[(n-7)/64][(n-7)%64] ^ got[(n-6)/64][(n-6)%64])) nrec++;
    check("prbs7_recurrence", 64'(nrec), 64'd0);
    for (int k = 0; k < 4; k++)
      check($sformatf("prbs7_period_%0d", k), got[k+127], ref_word(k));

    // PRBS15 under random backpressure, then stop while stalled.
    do_reset();
    pat_sel = 3'd3; pre_len = '0; set_model(3, 64); en = 1'b1;
    run_stream("prbs15_bp", 60, 1'b1, 0, 0, 1000);
    cmp_stream(ndiff, nbad, first);
    check("prbs15_vs_model", 64'(ndiff), 64'd0);
    check("prbs15_word_cnt", 64'(word_cnt), 64'd60);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stop_hold_valid%0d", i), 64'(tx_if.tx_valid), 64'd1);
      check($sformatf("stop_hold_data%0d", i), tx_if.tx_data, ref_word(60));
    end
    tx_if.tx_ready = 1'b1;
    step();
    check("stop_valid", 64'(tx_if.tx_valid), 64'd0);
    check("stop_state", 64'(state), 64'd0);
    check("stop_word_cnt", 64'(word_cnt), 64'd61);
    en = 1'b1; pre_len = 10'd3;
    step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("restart_pre_state%0d", i), 64'(state), 64'd1);
      check($sformatf("restart_pre_data%0d", i), tx_if.tx_data, CLK_W);
      step();
    end
    check("restart_payload_state", 64'(state), 64'd2);
    check("restart_payload_w0", tx_if.tx_data, ref_word(0));

    // Random pattern/preamble/backpressure mixes.
    for (int it = 0; it < 4; it++) begin
      do_reset();
      pat_sel = 3'($urandom_range(0, 7)); pre_len = 10'($urandom_range(0, 3));
      set_model(int'(pat_sel), 24); en = 1'b1;
      run_stream($sformatf("rand%0d", it), 20, 1'b1, 0, 0, 600);
      cmp_stream(ndiff, nbad, first);
      check($sformatf("rand%0d_vs_model", it), 64'(ndiff), 64'd0);
      check($sformatf("rand%0d_word_cnt", it), 64'(word_cnt), 64'd20);
    end

    // Error injection: pulse during preamble lands on the first payload word.
    do_reset();
    pat_sel = 3'd4; pre_len = 10'd3; set_model(4, 48); en = 1'b1;
    run_stream("inj_pre", 20, 1'b0, 1, 1, 200);
    cmp_stream(ndiff, nbad, first);
    check("inj_pre_ndiff", 64'(ndiff), 64'(InjOn));
    check("inj_pre_onlybit0", 64'(nbad), 64'd0);
    check("inj_pre_first", 64'(first), InjOn != 0 ? 64'd0 : 64'(-1));
    check("inj_pre_err_cnt", 64'(err_cnt), 64'(InjOn));

    do_reset();
    pat_sel = 3'd4; pre_len = '0; en = 1'b1;
    run_stream("inj_bp", 40, 1'b1, 15, 1, 1000);
    cmp_stream(ndiff, nbad, first);
    check("inj_bp_ndiff", 64'(ndiff), 64'(InjOn));
    check("inj_bp_onlybit0", 64'(nbad), 64'd0);
    check("inj_bp_err_cnt", 64'(err_cnt), 64'(InjOn));

    // Pulse held over several cycles while the request is pending: one error only.
    do_reset();
    pat_sel = 3'd4; pre_len = '0; en = 1'b1;
    run_stream("inj_dbl", 20, 1'b0, 5, 3, 200);
    cmp_stream(ndiff, nbad, first);
    check("inj_dbl_ndiff", 64'(ndiff), 64'(InjOn));
    check("inj_dbl_err_cnt", 64'(err_cnt), 64'(InjOn));

    // Reset in the middle of a payload, then restart from the seed.
    do_reset();
    pat_sel = 3'd4; pre_len = '0; en = 1'b1;
    run_stream("mid_a", 5, 1'b0, 0, 0, 100);
    rst = 1'b1; tx_if.tx_ready = 1'b1;
    step();
    check("midrst_valid", 64'(tx_if.tx_valid), 64'd0);
    check("midrst_word_cnt", 64'(word_cnt), 64'd0);
    check("midrst_state", 64'(state), 64'd0);
    rst = 1'b0;
    run_stream("mid_b", 4, 1'b0, 0, 0, 100);
    cmp_stream(ndiff, nbad, first);
    check("midrst_reseed", 64'(ndiff), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
